// File: rtl/rptr_empty_ctrl.sv
// rptr_empty_ctrl
//   Read-side pointer and status logic for an asynchronous FIFO. It keeps a
//   binary read pointer and a Gray-coded copy of it for crossing into the
//   write domain. It derives empty, almost-empty and fill level from a write
//   pointer that has already been synchronised into this domain. It also
//   keeps a sticky underflow flag.
//
//   Ports
//     i_rclk           read-domain clock, all state updates on rising edge
//     i_rrst_n         synchronous active-low reset
//     i_wptr_sync      Gray-coded write pointer, already in i_rclk domain
//     i_r_en           read request
//     i_clr_err        clears the sticky underflow flag
//     o_raddr          RAM read address (low bits of binary read pointer)
//     o_rptr           registered Gray-coded read pointer
//     o_rempty_flag    registered FIFO empty
//     o_ralmost_empty  registered, fill level <= AEMPTY_TH
//     o_rlevel         registered fill level, 0..2^ADDRSIZE
//     o_runderflow     sticky, a read was attempted while empty
module rptr_empty_ctrl #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                i_rclk,
  input  logic                i_rrst_n,
  input  logic [ADDRSIZE:0]   i_wptr_sync,
  input  logic                i_r_en,
  input  logic                i_clr_err,
  output logic [ADDRSIZE-1:0] o_raddr,
  output logic [ADDRSIZE:0]   o_rptr,
  output logic                o_rempty_flag,
  output logic                o_ralmost_empty,
  output logic [ADDRSIZE:0]   o_rlevel,
  output logic                o_runderflow
);

  localparam logic [ADDRSIZE:0] AEMPTY_TH_W = AEMPTY_TH[ADDRSIZE:0];

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              runderflow_q, runderflow_d;

  logic              rd_accept;
  logic [ADDRSIZE:0] wbin_sync;

  always_comb begin
    rd_accept = i_r_en & ~rempty_q;
    rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, rd_accept};
    rptr_d    = (rbin_d >> 1) ^ rbin_d;

    // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
    wbin_sync           = '0;
    wbin_sync[ADDRSIZE] = i_wptr_sync[ADDRSIZE];
    for (int unsigned k = 0; k < ADDRSIZE; k++) begin
      wbin_sync[ADDRSIZE-1-k] = wbin_sync[ADDRSIZE-k] ^ i_wptr_sync[ADDRSIZE-1-k];
    end

    rempty_d  = (rptr_d == i_wptr_sync);
    rlevel_d  = wbin_sync - rbin_d;
    raempty_d = (rlevel_d <= AEMPTY_TH_W);

    // Set takes priority over clear.
    runderflow_d = (i_r_en & rempty_q) | (runderflow_q & ~i_clr_err);
  end

  always_ff @(posedge i_rclk) begin
    if (!i_rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      rlevel_q     <= rlevel_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign o_raddr         = rbin_q[ADDRSIZE-1:0];
  assign o_rptr          = rptr_q;
  assign o_rempty_flag   = rempty_q;
  assign o_ralmost_empty = raempty_q;
  assign o_rlevel        = rlevel_q;
  assign o_runderflow    = runderflow_q;

endmodule

// File: doc/rptr_empty_ctrl.md
RPTR_EMPTY_CTRL -- requirements
Module: rptr_empty_ctrl

Interface
REQ-001 Parameter: ADDRSIZE, default 4, FIFO address width; depth = 2^ADDRSIZE.
REQ-002 Parameter: AEMPTY_TH, default 2, almost-empty threshold in entries; legal range 0..2^ADDRSIZE-1.
REQ-003 i_rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 i_rrst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 i_wptr_sync  input  ADDRSIZE+1  write pointer, Gray-coded, already synchronized into i_rclk domain.
REQ-006 i_r_en  input  1  read request.
REQ-007 i_clr_err  input  1  clears sticky underflow flag.
REQ-008 o_raddr  output  ADDRSIZE  RAM read address.
REQ-009 o_rptr  output  ADDRSIZE+1  read pointer, Gray-coded, registered, for crossing to write domain.
REQ-010 o_rempty_flag  output  1  FIFO empty, registered.
REQ-011 o_ralmost_empty  output  1  fill level <= AEMPTY_TH, registered.
REQ-012 o_rlevel  output  ADDRSIZE+1  fill level as seen by read side, registered, 0..2^ADDRSIZE.
REQ-013 o_runderflow  output  1  sticky: read attempted while empty.

Function
REQ-014 Internal binary read pointer rbin, ADDRSIZE+1 bits; o_raddr SHALL equal rbin[ADDRSIZE-1:0] combinationally.
REQ-015 Read accepted iff i_r_en=1 and o_rempty_flag=0; rbin_next = rbin + accepted, wrapping modulo 2^(ADDRSIZE+1).
REQ-016 rgray_next = (rbin_next >> 1) XOR rbin_next; each edge rbin <= rbin_next, o_rptr <= rgray_next.
REQ-017 o_rempty_flag <= (rgray_next == i_wptr_sync); empty asserts on the same edge that consumes the last entry.
REQ-018 wbin_sync SHALL be the Gray-to-binary conversion of i_wptr_sync: bit MSB copied, bit k = XOR of bits MSB..k.
REQ-019 o_rlevel <= (wbin_sync - rbin_next) modulo 2^(ADDRSIZE+1).
REQ-020 o_ralmost_empty <= (level_next <= AEMPTY_TH), level_next being the value loaded into o_rlevel.
REQ-021 Read with o_rempty_flag=1 SHALL be ignored (rbin, o_rptr unchanged) and SHALL set o_runderflow on the next edge.
REQ-022 o_runderflow held until i_clr_err=1; if set and clear coincide, set wins.
REQ-023 Wrap: pointer MSB toggles every 2^ADDRSIZE reads; empty/level stay correct across wrap, no special case.
REQ-024 Write-side advance and read on same edge: both reflected next cycle; empty only if rgray_next equals new i_wptr_sync.
REQ-025 Block SHALL NOT contain synchronizers; i_wptr_sync is used as-is (pessimistic empty by sync latency is accepted).

Reset
REQ-026 When i_rrst_n=0 at a rising edge: rbin=0, o_rptr=0, o_rempty_flag=1, o_ralmost_empty=1, o_rlevel=0, o_runderflow=0.
REQ-027 Reset SHALL take priority over i_r_en and i_clr_err; deasserting between edges SHALL NOT change state.
REQ-028 Outputs SHALL hold reset values until first edge with i_rrst_n=1.

Verification (ADDRSIZE=4, AEMPTY_TH=2)
REQ-029 Reset 2 cycles, i_wptr_sync=0 -> o_rempty_flag=1, o_rptr=0, o_raddr=0, o_rlevel=0, o_ralmost_empty=1, o_runderflow=0.
REQ-030 i_wptr_sync=5'b00010 (bin 3), no read -> next edge o_rempty_flag=0, o_rlevel=3, o_ralmost_empty=0.
REQ-031 Then i_r_en=1 for 3 cycles -> o_raddr 0,1,2; levels 2,1,0; o_ralmost_empty=1 after 1st read; o_rempty_flag=1 and o_rptr=5'b00010 after 3rd.
REQ-032 i_r_en=1 while empty -> rbin holds, o_runderflow=1 next edge, stays 1; i_clr_err=1 -> 0 next edge; clear with simultaneous underflow read -> stays 1.
REQ-033 Wrap: rbin=15, i_wptr_sync=gray(17)=5'b11001, read 2 -> o_raddr 15 then 0, o_rptr=5'b11001, o_rempty_flag=1, o_rlevel=0.
REQ-034 i_rrst_n pulsed low mid-stream with i_r_en=1 and level 5 -> reset values per REQ-026 at that edge; glitch low between edges -> no change.
